memory_arbiter: RTL and testbench
=================================

Name: memory_arbiter

Overview:
- Parametrised successor to the single-level memory controller. Arbitrates N CPUs' instruction-cache and data-cache requests onto one RAM port.
- Arbitration is round-robin within each class, data class over instruction class. The grant is registered and held for the whole transaction.
- Adds a per-transaction watchdog, RAM error reporting, and abort on request withdrawal.
- Sits between the per-CPU caches and the RAM model, in place of the combinational controller.

Parameters:
- CPUS, 2, number of CPUs; each has one I-port and one D-port.
- WORD_W, 32, data word width.
- ADDR_W, 32, address width.
- TIMEOUT, 255, max cycles in XFER before forced abort; 0 disables the watchdog.

Ports:
- CLK  in  1  clock, rising edge.
- RST  in  1  asynchronous active-high reset.
- iREN  in  CPUS  per-CPU instruction read request.
- iaddr  in  CPUS*ADDR_W  per-CPU instruction address; CPU i at bits [i*ADDR_W +: ADDR_W].
- dREN  in  CPUS  per-CPU data read request.
- dWEN  in  CPUS  per-CPU data write request.
- daddr  in  CPUS*ADDR_W  per-CPU data address.
- dstore  in  CPUS*WORD_W  per-CPU write data.
- iwait  out  CPUS  low for exactly one cycle when CPU i's instruction access completes.
- dwait  out  CPUS  low for exactly one cycle when CPU i's data access completes.
- iload  out  CPUS*WORD_W  ramload broadcast to every slice.
- dload  out  CPUS*WORD_W  ramload broadcast to every slice.
- ierr  out  CPUS  pulses with iwait low when the access ended in error or timeout.
- derr  out  CPUS  pulses with dwait low when the access ended in error or timeout.
- ramREN  out  1  RAM read enable.
- ramWEN  out  1  RAM write enable.
- ramaddr  out  ADDR_W  RAM address.
- ramstore  out  WORD_W  RAM write data.
- ramload  in  WORD_W  RAM read data.
- ramstate  in  ramstate_t  RAM status from cpu_types_pkg: FREE, BUSY, ACCESS, ERROR.

Behaviour:
- Reset (async, RST=1):
  - state=IDLE; d_ptr=0, i_ptr=0; watchdog counter=0.
  - Outputs: iwait='1, dwait='1, ierr=0, derr=0, ramREN=0, ramWEN=0, ramaddr=0, ramstore=0.
  - Reset mid-transaction drops the RAM strobes immediately and asserts no completion.
- FSM states: IDLE, XFER.
- IDLE:
  - No RAM strobes.
  - If any dREN|dWEN is set, pick the first requesting CPU at or after d_ptr (wrapping modulo CPUS). Register owner=CPU, class=D, and write=dWEN[owner].
  - Otherwise, if any iREN is set, pick the same way from i_ptr with class=I.
  - On a pick, go to XFER. Grant latency is 1 cycle.
- XFER, RAM drive:
  - Owner's address drives ramaddr.
  - Class D with write=1: ramWEN=1, ramstore=owner's dstore.
  - Otherwise: ramREN=1.
  - If dREN and dWEN are both set on the owner, the access is a write.
- XFER, completion:
  - ramstate==ACCESS: owner's wait goes low this cycle (combinational); pointer of the served class = (owner+1) mod CPUS; next state IDLE.
  - ramstate==ERROR: same as ACCESS, plus owner's err pulses.
  - Watchdog (TIMEOUT>0): counter increments each XFER cycle and clears on leaving XFER. When counter==TIMEOUT-1 without ACCESS/ERROR: complete with err pulse, advance pointer, go to IDLE.
- XFER, withdrawal:
  - Owner's request deasserted before completion means abort: strobes drop that cycle, no wait/err pulse, pointer unchanged, next state IDLE.
  - Class D: the request is dREN|dWEN.
  - Changing dWEN→dREN mid-transfer is not supported; the latched write bit governs.
- Non-owners keep wait=1 throughout; their requests are ignored until IDLE.
- A requester still asserting after completion re-arbitrates normally. Back-to-back service of one CPU is possible only if no other CPU in that class requests.
- Minimum transaction: 2 cycles (IDLE grant + 1 XFER cycle), giving at most one completion per 2 cycles.
- iload/dload broadcast ramload to every slice; only meaningful to a requester when its wait is low.
- CPUS=1: both pointers stay 0.

Test Plan:
- Reset mid-XFER: dREN[0]=1, daddr0=0x40, RAM BUSY, RST=1 for 1 cycle → ramREN=0 the same cycle; dwait='1; state IDLE; d_ptr=0.
- Data over instruction: iREN=2'b11, dREN=2'b10, ramstate ACCESS on the 1st XFER cycle → CPU1 D served first (ramaddr=daddr1, dwait[1]=0 for one cycle), then I-port CPU0 served.
- Round-robin fairness: CPUS=4, dWEN=4'b1111 held, RAM completes on the 2nd XFER cycle → grants 0,1,2,3,0 in that order; ramstore matches each owner; each completion 3 cycles apart.
- Error path: iREN[1]=1, ramstate=ERROR on 1st XFER cycle → iwait[1]=0 and ierr[1]=1 for exactly that cycle; i_ptr=0 afterwards.
- Watchdog: TIMEOUT=8, dREN[0]=1, ramstate held BUSY → dwait[0]=0 and derr[0]=1 on the 8th XFER cycle; ramREN=0 the next cycle.
- Withdrawal: dWEN[1]=1, dropped on 2nd XFER cycle with RAM BUSY → ramWEN=0 that cycle; no dwait/derr pulse; d_ptr unchanged; next grant from d_ptr again.

Source files
------------

// File: rtl/memory_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | memory_arbiter : arbitrates per-CPU I/D cache requests onto one RAM port |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+

package cpu_types_pkg;
  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;
endpackage

module memory_arbiter
  import cpu_types_pkg::*;
#(
  parameter int CPUS    = 2,
  parameter int WORD_W  = 32,
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic [CPUS-1:0]          iREN,
  input  logic [CPUS*ADDR_W-1:0]   iaddr,
  input  logic [CPUS-1:0]          dREN,
  input  logic [CPUS-1:0]          dWEN,
  input  logic [CPUS*ADDR_W-1:0]   daddr,
  input  logic [CPUS*WORD_W-1:0]   dstore,
  output logic [CPUS-1:0]          iwait,
  output logic [CPUS-1:0]          dwait,
  output logic [CPUS*WORD_W-1:0]   iload,
  output logic [CPUS*WORD_W-1:0]   dload,
  output logic [CPUS-1:0]          ierr,
  output logic [CPUS-1:0]          derr,
  output logic                     ramREN,
  output logic                     ramWEN,
  output logic [ADDR_W-1:0]        ramaddr,
  output logic [WORD_W-1:0]        ramstore,
  input  logic [WORD_W-1:0]        ramload,
  input  ramstate_t                ramstate
);

  localparam int C_IDX_W = (CPUS > 1) ? $clog2(CPUS) : 1;
  localparam int C_CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [C_CNT_W-1:0] C_WDOG_LAST = C_CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam logic [C_IDX_W-1:0] C_LAST_CPU  = C_IDX_W'(CPUS - 1);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    XFER = 1'b1
  } state_t;

  state_t               state_q, state_d;
  logic [C_IDX_W-1:0]   owner_q, owner_d;
  logic [C_IDX_W-1:0]   d_ptr_q, d_ptr_d;
  logic [C_IDX_W-1:0]   i_ptr_q, i_ptr_d;
  logic                 cls_d_q, cls_d_d;
  logic                 write_q, write_d;
  logic [C_CNT_W-1:0]   wdog_q, wdog_d;

  logic [CPUS-1:0]      w_d_req;
  logic [C_IDX_W:0]     w_d_pick;
  logic [C_IDX_W:0]     w_i_pick;
  logic                 w_own_req;
  logic                 w_active;
  logic                 w_done;
  logic                 w_err;
  logic [C_IDX_W-1:0]   w_owner_next;
  logic [ADDR_W-1:0]    w_addr_sel;
  logic [WORD_W-1:0]    w_store_sel;

  // Returns {found, index} of the first set request at or after ptr, wrapping.
  function automatic logic [C_IDX_W:0] rr_pick(input logic [CPUS-1:0] req,
                                               input logic [C_IDX_W-1:0] ptr);
    logic [C_IDX_W:0]   res;
    logic [C_IDX_W-1:0] idx;
    res = '0;
    for (int k = CPUS - 1; k >= 0; k--) begin
      idx = C_IDX_W'((int'(ptr) + k) % CPUS);
      if (req[idx]) res = {1'b1, idx};
    end
    return res;
  endfunction

  assign w_d_req      = dREN | dWEN;
  assign w_d_pick     = rr_pick(w_d_req, d_ptr_q);
  assign w_i_pick     = rr_pick(iREN, i_ptr_q);
  assign w_own_req    = cls_d_q ? w_d_req[owner_q] : iREN[owner_q];
  assign w_active     = (state_q == XFER) && w_own_req;
  assign w_owner_next = (owner_q == C_LAST_CPU) ? '0 : owner_q + 1'b1;

  always_comb begin
    w_addr_sel  = '0;
    w_store_sel = '0;
    for (int c = 0; c < CPUS; c++) begin
      if (owner_q == C_IDX_W'(c)) begin
        w_addr_sel  = cls_d_q ? daddr[c*ADDR_W +: ADDR_W] : iaddr[c*ADDR_W +: ADDR_W];
        w_store_sel = dstore[c*WORD_W +: WORD_W];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    cls_d_d = cls_d_q;
    write_d = write_q;
    d_ptr_d = d_ptr_q;
    i_ptr_d = i_ptr_q;
    wdog_d  = '0;
    w_done  = 1'b0;
    w_err   = 1'b0;
    case (state_q)
      IDLE: begin
        if (w_d_pick[C_IDX_W]) begin
          owner_d = w_d_pick[C_IDX_W-1:0];
          cls_d_d = 1'b1;
          write_d = dWEN[w_d_pick[C_IDX_W-1:0]];
          state_d = XFER;
        end else if (w_i_pick[C_IDX_W]) begin
          owner_d = w_i_pick[C_IDX_W-1:0];
          cls_d_d = 1'b0;
          write_d = 1'b0;
          state_d = XFER;
        end
      end
      XFER: begin
        // Withdrawal wins over a same-cycle completion: the strobes are already gone.
        if (!w_own_req) begin
          state_d = IDLE;
        end else if ((ramstate == ACCESS) || (ramstate == ERROR) ||
                     ((TIMEOUT > 0) && (wdog_q == C_WDOG_LAST))) begin
          w_done  = 1'b1;
          w_err   = (ramstate != ACCESS);
          state_d = IDLE;
          if (cls_d_q) d_ptr_d = w_owner_next;
          else         i_ptr_d = w_owner_next;
        end else if (TIMEOUT > 0) begin
          wdog_d = wdog_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= IDLE;
      owner_q <= '0;
      cls_d_q <= 1'b0;
      write_q <= 1'b0;
      d_ptr_q <= '0;
      i_ptr_q <= '0;
      wdog_q  <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      cls_d_q <= cls_d_d;
      write_q <= write_d;
      d_ptr_q <= d_ptr_d;
      i_ptr_q <= i_ptr_d;
      wdog_q  <= wdog_d;
    end
  end

  assign ramWEN   = w_active && cls_d_q && write_q;
  assign ramREN   = w_active && !(cls_d_q && write_q);
  assign ramaddr  = w_active ? w_addr_sel : '0;
  assign ramstore = ramWEN ? w_store_sel : '0;
  assign iload    = {CPUS{ramload}};
  assign dload    = {CPUS{ramload}};

  always_comb begin
    for (int c = 0; c < CPUS; c++) begin
      iwait[c] = !(w_done && !cls_d_q && (owner_q == C_IDX_W'(c)));
      dwait[c] = !(w_done &&  cls_d_q && (owner_q == C_IDX_W'(c)));
      ierr[c]  =   w_err  && !cls_d_q && (owner_q == C_IDX_W'(c));
      derr[c]  =   w_err  &&  cls_d_q && (owner_q == C_IDX_W'(c));
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_memory_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_memory_arbiter : directed self-checking bench for memory_arbiter       |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+

module tb_memory_arbiter;
  import cpu_types_pkg::*;

  localparam int N = 4;
  localparam int W = 32;
  localparam int A = 32;

  logic           CLK = 1'b0;
  logic           RST = 1'b0;
  logic [N-1:0]   iREN = '0, dREN = '0, dWEN = '0;
  logic [N*A-1:0] iaddr = '0, daddr = '0;
  logic [N*W-1:0] dstore = '0;
  logic [N-1:0]   iwait, dwait, ierr, derr;
  logic [N*W-1:0] iload, dload;
  logic           ramREN, ramWEN;
  logic [A-1:0]   ramaddr;
  logic [W-1:0]   ramstore;
  logic [W-1:0]   ramload = 32'hCAFE_0001;
  ramstate_t      ramstate = FREE;

  int total = 0;
  int bad   = 0;

  always #5 CLK = ~CLK;

  memory_arbiter #(.CPUS(N), .WORD_W(W), .ADDR_W(A), .TIMEOUT(8)) dut (
    .CLK(CLK), .RST(RST),
    .iREN(iREN), .iaddr(iaddr), .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
    .iwait(iwait), .dwait(dwait), .iload(iload), .dload(dload), .ierr(ierr), .derr(derr),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ramstate(ramstate)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic nxt();
    @(negedge CLK);
  endtask

  initial begin
    logic [N-1:0] exp_w;
    int own;

    // reset state
    #1 RST = 1'b1;
    nxt(); #1;
    check("rst_iwait", iwait, 4'hF);
    check("rst_dwait", dwait, 4'hF);
    check("rst_err", {ierr, derr}, 8'h00);
    check("rst_strobes", {ramREN, ramWEN}, 2'b00);
    check("rst_addr", ramaddr, 32'h0);
    check("rst_store", ramstore, 32'h0);
    nxt(); RST = 1'b0;

    // reset in the middle of a transfer
    nxt(); dREN = 4'b0001; daddr[0 +: A] = 32'h40; ramstate = BUSY;
    nxt(); #1;
    check("a_ren", ramREN, 1'b1);
    check("a_addr", ramaddr, 32'h40);
    RST = 1'b1; #1;
    check("a_ren_rst", ramREN, 1'b0);
    check("a_dwait_rst", dwait, 4'hF);
    nxt(); RST = 1'b0; dREN = '0; ramstate = FREE;

    // data class beats instruction class
    daddr[0 +: A] = 32'h100; daddr[A +: A] = 32'h140;
    iaddr[0 +: A] = 32'h200; iaddr[A +: A] = 32'h240; iaddr[2*A +: A] = 32'h280;
    nxt(); iREN = 4'b0011; dREN = 4'b0010; ramstate = ACCESS; #1;
    check("b_idle_ren", ramREN, 1'b0);
    nxt(); #1;
    check("b_d_addr", ramaddr, 32'h140);
    check("b_d_ren", ramREN, 1'b1);
    check("b_dwait", dwait, 4'b1101);
    check("b_iwait_hold", iwait, 4'hF);
    check("b_dload1", dload[W +: W], 32'hCAFE_0001);
    nxt(); dREN = '0; #1;
    check("b_dwait_one", dwait, 4'hF);
    nxt(); #1;
    check("b_i_addr", ramaddr, 32'h200);
    check("b_iwait", iwait, 4'b1110);
    nxt(); iREN = '0;

    // error completion
    nxt(); iREN = 4'b0010; ramstate = ERROR;
    nxt(); #1;
    check("d_addr", ramaddr, 32'h240);
    check("d_iwait", iwait, 4'b1101);
    check("d_ierr", ierr, 4'b0010);
    nxt(); iREN = '0; #1;
    check("d_ierr_one", ierr, 4'b0000);
    check("d_iwait_one", iwait, 4'hF);
    // i_ptr advanced to 2: of CPUs 0 and 2, CPU 2 goes first
    nxt(); iREN = 4'b0101; ramstate = ACCESS;
    nxt(); #1;
    check("d_ptr_addr", ramaddr, 32'h280);
    check("d_ptr_iwait", iwait, 4'b1011);
    nxt(); iREN = '0;

    // round-robin writes from a fresh reset
    nxt(); RST = 1'b1;
    nxt(); RST = 1'b0;
    for (int c = 0; c < N; c++) begin
      daddr[c*A +: A]  = 32'h1000 + 32'(c * 4);
      dstore[c*W +: W] = 32'hD000_0000 + 32'(c);
    end
    nxt(); dWEN = 4'b1111; ramstate = BUSY;
    for (int k = 0; k < 5; k++) begin
      own = k % N;
      exp_w = 4'hF;
      exp_w[own] = 1'b0;
      nxt(); #1;
      check("c_wen", ramWEN, 1'b1);
      check("c_addr", ramaddr, 32'h1000 + 32'(own * 4));
      check("c_store", ramstore, 32'hD000_0000 + 32'(own));
      check("c_busy_dwait", dwait, 4'hF);
      nxt(); ramstate = ACCESS; #1;
      check("c_dwait", dwait, exp_w);
      nxt(); ramstate = BUSY; if (k == 4) dWEN = '0; #1;
      check("c_idle_dwait", dwait, 4'hF);
      check("c_idle_wen", ramWEN, 1'b0);
    end

    // watchdog: d_ptr is 1, only CPU 0 requests
    daddr[0 +: A] = 32'h40;
    nxt(); dREN = 4'b0001;
    for (int c = 1; c < 8; c++) begin
      nxt(); #1;
      check("e_wait_busy", dwait, 4'hF);
      check("e_ren_busy", ramREN, 1'b1);
    end
    nxt(); #1;
    check("e_dwait", dwait, 4'b1110);
    check("e_derr", derr, 4'b0001);
    nxt(); dREN = '0; #1;
    check("e_ren_after", ramREN, 1'b0);
    check("e_derr_after", derr, 4'b0000);

    // withdrawal: d_ptr still 1
    nxt(); dWEN = 4'b0010;
    nxt(); #1;
    check("f_wen", ramWEN, 1'b1);
    nxt(); dWEN = '0; #1;
    check("f_wen_drop", ramWEN, 1'b0);
    check("f_dwait", dwait, 4'hF);
    check("f_derr", derr, 4'b0000);
    nxt(); dREN = 4'b0011; ramstate = ACCESS; #1;
    check("f_idle_ren", ramREN, 1'b0);
    nxt(); #1;
    check("f_regrant_addr", ramaddr, 32'h1004);
    check("f_regrant_dwait", dwait, 4'b1101);
    nxt(); dREN = '0;
    nxt();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
